dht11_interface: RTL

//  Single-wire DHT11 driver feeding the TUSCA control unit: on a medir pulse it sends the start

---
 rtl/dht11_interface.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/dht11_interface.sv
// dht11_interface: single-wire DHT11 driver.
// On a medir pulse it pulls the data line low for START_US, releases it, follows the
// sensor's response and 40 data bits, validates the checksum and reports the result
// with a one-cycle pronto. The data pin is open-drain off-chip (dht_oe=1 pulls low).
module dht11_interface #(
    parameter int CICLOS_US  = 50,
    parameter int START_US   = 18000,
    parameter int TIMEOUT_US = 100,
    parameter int LIMIAR_US  = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       medir,
    input  logic       dht_in,
    output logic       dht_oe,
    output logic       pronto,
    output logic [7:0] umidade_int,
    output logic [7:0] umidade_dec,
    output logic [7:0] temperatura_int,
    output logic [7:0] temperatura_dec,
    output logic       erro_checksum,
    output logic       erro_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        START_LOW = 4'd1,
        LIBERA    = 4'd2,
        RESP_LOW  = 4'd3,
        RESP_HIGH = 4'd4,
        BIT_LOW   = 4'd5,
        BIT_HIGH  = 4'd6,
        CONCLUI   = 4'd7,
        ERRO      = 4'd8
    } estado_t;

    localparam int            PW          = (CICLOS_US > 1) ? $clog2(CICLOS_US) : 1;
    localparam logic [PW-1:0] PRESC_MAX   = PW'(CICLOS_US - 1);
    localparam logic [15:0]   START_LIM   = 16'(START_US);
    localparam logic [15:0]   TIMEOUT_LIM = 16'(TIMEOUT_US);
    localparam logic [15:0]   LIMIAR_LIM  = 16'(LIMIAR_US);

    estado_t       estado;
    logic [PW-1:0] presc;
    logic [14:0]   us_cnt;
    logic          tick;
    logic [15:0]   us_dec;
    logic [2:0]    sinc;
    logic          sobe;
    logic          desce;
    logic [5:0]    bit_cnt;
    logic [39:0]   dados;
    logic [7:0]    soma;
    logic          tempo_esgotado;

    // Microseconds spent in the current state, counting the cycle now being evaluated,
    // so a line held for N us compares as N and START_LOW lasts exactly START_US us.
    assign tick           = (presc == PRESC_MAX);
    assign us_dec         = {1'b0, us_cnt} + {15'd0, tick};
    assign tempo_esgotado = (us_dec > TIMEOUT_LIM);

    // sinc[1] is the synchronised line, sinc[2] its previous value.
    assign sobe  = sinc[1] & ~sinc[2];
    assign desce = ~sinc[1] & sinc[2];

    // Frame arrives MSB first: byte0 in dados[39:32], checksum byte in dados[7:0].
    assign soma      = dados[39:32] + dados[31:24] + dados[23:16] + dados[15:8];
    assign db_estado = estado;

    // Two-flop synchroniser for the asynchronous pin plus one delay stage for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sinc <= 3'b111;
        end else begin
            sinc <= {sinc[1:0], dht_in};
        end
    end

    // Protocol FSM with us timing, bit capture and registered outputs.
    // NOTE: all state here uses non-blocking assignments; a transition's later assignments
    // override the per-cycle defaults written at the top of the block.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado          <= OCIOSO;
            presc           <= '0;
            us_cnt          <= '0;
            bit_cnt         <= '0;
            dados           <= '0;
            dht_oe          <= 1'b0;
            pronto          <= 1'b0;
            umidade_int     <= '0;
            umidade_dec     <= '0;
            temperatura_int <= '0;
            temperatura_dec <= '0;
            erro_checksum   <= 1'b0;
            erro_timeout    <= 1'b0;
        end else begin
            pronto <= 1'b0;

            if (estado != OCIOSO) begin
                if (tick) begin
                    presc  <= '0;
                    us_cnt <= us_cnt + 15'd1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end

            case (estado)
                OCIOSO: begin
                    // A request coinciding with the previous pronto is dropped.
                    if (medir && !pronto) begin
                        estado  <= START_LOW;
                        dht_oe  <= 1'b1;
                        bit_cnt <= '0;
                        presc   <= '0;
                        us_cnt  <= '0;
                    end
                end
                START_LOW: begin
                    if (us_dec >= START_LIM) begin
                        estado <= LIBERA;
                        dht_oe <= 1'b0;
                        presc  <= '0;
                        us_cnt <= '0;
                    end
                end
                LIBERA: begin
                    if (desce) begin
                        estado <= RESP_LOW;
                        presc  <= '0;
                        us_cnt <= '0;
                    end else if (tempo_esgotado) begin
                        estado <= ERRO;
                        presc  <= '0;
                        us_cnt <= '0;
                    end
                end
                RESP_LOW: begin
                    if (sobe) begin
                        estado <= RESP_HIGH;
                        presc  <= '0;
                        us_cnt <= '0;
                    end else if (tempo_esgotado) begin
                        estado <= ERRO;
                        presc  <= '0;
                        us_cnt <= '0;
                    end
                end
                RESP_HIGH: begin
                    if (desce) begin
                        estado <= BIT_LOW;
                        presc  <= '0;
                        us_cnt <= '0;
                    end else if (tempo_esgotado) begin
                        estado <= ERRO;
                        presc  <= '0;
                        us_cnt <= '0;
                    end
                end
                BIT_LOW: begin
                    if (sobe) begin
                        estado <= BIT_HIGH;
                        presc  <= '0;
                        us_cnt <= '0;
                    end else if (tempo_esgotado) begin
                        estado <= ERRO;
                        presc  <= '0;
                        us_cnt <= '0;
                    end
                end
                BIT_HIGH: begin
                    // The length of the high pulse encodes the bit value.
                    if (desce) begin
                        dados   <= {dados[38:0], (us_dec >= LIMIAR_LIM)};
                        bit_cnt <= bit_cnt + 6'd1;
                        estado  <= (bit_cnt == 6'd39) ? CONCLUI : BIT_LOW;
                        presc   <= '0;
                        us_cnt  <= '0;
                    end else if (tempo_esgotado) begin
                        estado <= ERRO;
                        presc  <= '0;
                        us_cnt <= '0;
                    end
                end
                CONCLUI: begin
                    if (soma == dados[7:0]) begin
                        umidade_int     <= dados[39:32];
                        umidade_dec     <= dados[31:24];
                        temperatura_int <= dados[23:16];
                        temperatura_dec <= dados[15:8];
                        erro_checksum   <= 1'b0;
                    end else begin
                        erro_checksum <= 1'b1;
                    end
                    erro_timeout <= 1'b0;
                    pronto       <= 1'b1;
                    estado       <= OCIOSO;
                    presc        <= '0;
                    us_cnt       <= '0;
                end
                ERRO: begin
                    erro_timeout  <= 1'b1;
                    erro_checksum <= 1'b0;
                    pronto        <= 1'b1;
                    estado        <= OCIOSO;
                    presc         <= '0;
                    us_cnt        <= '0;
                end
                default: begin
                    estado <= OCIOSO;
                    dht_oe <= 1'b0;
                    presc  <= '0;
                    us_cnt <= '0;
                end
            endcase
        end
    end

endmodule
